// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: FSM encoding, RV32I encoding constants, program and readback sizes,
// and the LFSR tap mask.
package lbist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StRead,
    StCheck
  } lbist_state_e;

  localparam int unsigned ORA_WORDS  = 8;
  localparam int unsigned PROG_WORDS = 17;

  // x^12 + x^6 + x^4 + x + 1 -> state bits 11, 5, 3, 0
  localparam logic [11:0] LFSR_TAPS = 12'h829;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd);
    return {imm, rs1, f3, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
  endfunction

  // The operands go in raw as 12-bit immediates; the core sign-extends them like the analyzer.
  function automatic logic [31:0] prog_word(logic [4:0] k, logic [11:0] r1, logic [11:0] r2);
    logic [31:0] w;
    w = '0;
    if (k >= 5'd8 && k <= 5'd15) begin
      w = enc_s({7'd0, k[2:0], 2'b00}, k - 5'd7, 5'd0);
    end else begin
      case (k)
        5'd0:    w = enc_i(r1, 5'd0, F3_ADD, 5'd1);
        5'd1:    w = enc_i(r2, 5'd0, F3_ADD, 5'd2);
        5'd2:    w = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3);
        5'd3:    w = enc_r(F7_SUB, 5'd2, 5'd1, F3_ADD, 5'd4);
        5'd4:    w = enc_r(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd5);
        5'd5:    w = enc_r(F7_BASE, 5'd2, 5'd1, F3_OR, 5'd6);
        5'd6:    w = enc_i({F7_BASE, 5'd1}, 5'd1, F3_SLL, 5'd7);
        5'd7:    w = enc_i({F7_BASE, 5'd1}, 5'd2, F3_SRL, 5'd8);
        5'd16:   w = {20'd0, 5'd0, OPC_JAL};
        default: w = '0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/lbist_tpg_if.sv
// Signal bundle between the LBIST pattern generator and its core / memory / analyzer environment.
interface lbist_tpg_if;
  logic        bist_start;
  logic        bist_busy;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic [31:0] dmem_raddr;
  logic        inst_end;
  logic [11:0] random_value_1;
  logic [11:0] random_value_2;
  logic        P_F;
  logic        bist_done;
  logic        bist_pass;

  modport master (
    input  bist_start, P_F,
    output bist_busy, imem_we, imem_addr, imem_wdata, core_rst, dmem_raddr, inst_end,
           random_value_1, random_value_2, bist_done, bist_pass
  );

  modport slave (
    output bist_start, P_F,
    input  bist_busy, imem_we, imem_addr, imem_wdata, core_rst, dmem_raddr, inst_end,
           random_value_1, random_value_2, bist_done, bist_pass
  );
endinterface

// File: rtl/lbist_lfsr12.sv
// 12-bit Fibonacci LFSR with a never-zero seed and state; steps once per cycle with step high.
module lbist_lfsr12
  import lbist_pkg::*;
#(
  parameter logic [11:0] SEED = 12'h001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [11:0] state,
  output logic [11:0] state_nxt
);

  localparam logic [11:0] Init = (SEED == 12'h000) ? 12'h001 : SEED;

  logic [11:0] state_q;
  logic [11:0] shifted;

  always_comb begin
    shifted   = {state_q[10:0], ^(state_q & LFSR_TAPS)};
    state_nxt = (shifted == 12'h000) ? 12'h001 : shifted;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Init;
    end else if (step) begin
      state_q <= state_nxt;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lbist_tpg.sv
// LBIST test-pattern generator: loads a short program into instruction memory, runs the core,
// then opens the readback window. Define LBIST_MULTI_ROUND_EN to run ROUNDS rounds per start.
module lbist_tpg
  import lbist_pkg::*;
#(
  parameter logic [11:0] SEED1      = 12'h123,
  parameter logic [11:0] SEED2      = 12'h456,
  parameter int unsigned RUN_CYCLES = 64,
  parameter int unsigned ROUNDS     = 4
) (
  input logic         clk,
  input logic         Rst,
  lbist_tpg_if.master bus
);

`ifdef LBIST_MULTI_ROUND_EN
  localparam int unsigned NumRounds = ROUNDS;
`else
  // Single round; ROUNDS has no effect in this build.
  localparam int unsigned NumRounds = (ROUNDS * 0) + 1;
`endif

  lbist_state_e state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  round_q, round_d;
  logic         acc_q, acc_d;
  logic         pass_q, pass_d;
  logic [11:0]  rv1_q, rv1_d, rv2_q, rv2_d;
  logic         step;
  logic [11:0]  lfsr1, lfsr1_nxt, lfsr2, lfsr2_nxt;

  lbist_lfsr12 #(.SEED(SEED1)) u_lfsr1 (
    .clk       (clk),
    .rst       (Rst),
    .step      (step),
    .state     (lfsr1),
    .state_nxt (lfsr1_nxt)
  );

  lbist_lfsr12 #(.SEED(SEED2)) u_lfsr2 (
    .clk       (clk),
    .rst       (Rst),
    .step      (step),
    .state     (lfsr2),
    .state_nxt (lfsr2_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    acc_d   = acc_q;
    pass_d  = pass_q;
    rv1_d   = rv1_q;
    rv2_d   = rv2_q;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.bist_start) begin
          state_d = StLoad;
          cnt_d   = '0;
          round_d = '0;
          acc_d   = 1'b1;
          rv1_d   = lfsr1;
          rv2_d   = lfsr2;
        end
      end
      StLoad: begin
        if (cnt_q == PROG_WORDS - 1) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRun: begin
        if (cnt_q == RUN_CYCLES - 1) begin
          state_d = StRead;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRead: begin
        // The 9th readback cycle carries the analyzer verdict.
        if (cnt_q == ORA_WORDS) begin
          cnt_d = '0;
          acc_d = acc_q & bus.P_F;
          if (round_q == NumRounds - 1) begin
            state_d = StCheck;
            pass_d  = acc_q & bus.P_F;
          end else begin
            state_d = StLoad;
            round_d = round_q + 32'd1;
            step    = 1'b1;
            rv1_d   = lfsr1_nxt;
            rv2_d   = lfsr2_nxt;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StCheck: begin
        step    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      round_q <= '0;
      acc_q   <= 1'b0;
      pass_q  <= 1'b0;
      rv1_q   <= '0;
      rv2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      acc_q   <= acc_d;
      pass_q  <= pass_d;
      rv1_q   <= rv1_d;
      rv2_q   <= rv2_d;
    end
  end

  assign bus.bist_busy      = (state_q != StIdle);
  assign bus.imem_we        = (state_q == StLoad);
  assign bus.imem_addr      = (state_q == StLoad) ? {cnt_q[29:0], 2'b00} : '0;
  assign bus.imem_wdata     = (state_q == StLoad) ? prog_word(cnt_q[4:0], rv1_q, rv2_q) : '0;
  assign bus.core_rst       = (state_q != StRun);
  assign bus.inst_end       = (state_q == StRead);
  assign bus.dmem_raddr     = (state_q == StRead && cnt_q < ORA_WORDS) ? {cnt_q[29:0], 2'b00}
                                                                       : '0;
  assign bus.bist_done      = (state_q == StCheck);
  assign bus.bist_pass      = pass_q;
  assign bus.random_value_1 = rv1_q;
  assign bus.random_value_2 = rv2_q;

endmodule

// File: tb/tb_lbist_tpg.sv
// Self-checking bench for lbist_tpg: table of start/verdict runs with a write scoreboard, plus
// seed-zero, mid-run reset and start-while-busy sequences.
module tb_lbist_tpg;

  localparam int unsigned RunCycles = 64;
  localparam int unsigned DoneAt    = 1 + 17 + RunCycles + 9;

  typedef struct {
    logic        pf;
    logic [11:0] rv1;
    logic [11:0] rv2;
    logic        exp_pass;
  } run_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] sb_addr[$];
  logic [31:0] sb_word[$];
  logic [31:0] fixed_words[17];
  run_rec_t    runs[3];

  lbist_tpg_if bus0 ();
  lbist_tpg_if bus1 ();

  lbist_tpg dut0 (
    .clk (clk),
    .Rst (rst),
    .bus (bus0)
  );

  lbist_tpg #(.SEED1(12'h000), .RUN_CYCLES(8)) dut1 (
    .clk (clk),
    .Rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_run(input run_rec_t r);
    int cyc;
    int we_cnt;
    int run_cnt;
    int rd_cnt;
    int done_cnt;
    int done_at;
    logic [31:0] a_exp;
    logic [31:0] w_exp;
    we_cnt   = 0;
    run_cnt  = 0;
    rd_cnt   = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int k = 0; k < 17; k++) begin
      sb_addr.push_back(32'(4 * k));
      if (k == 0)      sb_word.push_back({r.rv1, 20'h00093});
      else if (k == 1) sb_word.push_back({r.rv2, 20'h00113});
      else             sb_word.push_back(fixed_words[k]);
    end
    @(negedge clk);
    bus0.P_F        = ~r.pf;
    bus0.bist_start = 1'b1;
    for (cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus0.bist_start = 1'b0;
        check("rv1_latched", {20'd0, bus0.random_value_1}, {20'd0, r.rv1});
        check("rv2_latched", {20'd0, bus0.random_value_2}, {20'd0, r.rv2});
        check("busy_in_load", {31'd0, bus0.bist_busy}, 32'd1);
      end
      if (bus0.imem_we) begin
        we_cnt++;
        if (sb_addr.size() == 0) begin
          check("imem_extra_write", 32'(we_cnt), 32'd17);
        end else begin
          a_exp = sb_addr.pop_front();
          w_exp = sb_word.pop_front();
          check("imem_addr", bus0.imem_addr, a_exp);
          check("imem_wdata", bus0.imem_wdata, w_exp);
        end
      end
      if (!bus0.core_rst) run_cnt++;
      if (bus0.inst_end) begin
        check("dmem_raddr", bus0.dmem_raddr, (rd_cnt < 8) ? 32'(4 * rd_cnt) : 32'd0);
        rd_cnt++;
        bus0.P_F = (rd_cnt == 9) ? r.pf : ~r.pf;
      end
      if (bus0.bist_done) begin
        done_cnt++;
        if (done_cnt == 1) done_at = cyc;
        check("pass_at_done", {31'd0, bus0.bist_pass}, {31'd0, r.exp_pass});
      end else if (done_cnt > 0) begin
        break;
      end
      // A second start during LOAD must be ignored.
      if (cyc == 3) bus0.bist_start = 1'b1;
      if (cyc == 4) bus0.bist_start = 1'b0;
    end
    check("done_seen", 32'(done_cnt), 32'd1);
    check("done_latency", 32'(done_at), 32'(DoneAt));
    check("imem_write_count", 32'(we_cnt), 32'd17);
    check("run_cycle_count", 32'(run_cnt), 32'(RunCycles));
    check("inst_end_count", 32'(rd_cnt), 32'd9);
    check("sb_empty", 32'(sb_addr.size()), 32'd0);
    check("busy_after_done", {31'd0, bus0.bist_busy}, 32'd0);
    check("pass_sticky", {31'd0, bus0.bist_pass}, {31'd0, r.exp_pass});
    sb_addr.delete();
    sb_word.delete();
  endtask

  task automatic reset_mid_run();
    int run_cnt;
    int done_seen;
    run_cnt   = 0;
    done_seen = 0;
    @(negedge clk);
    bus0.bist_start = 1'b1;
    @(negedge clk);
    bus0.bist_start = 1'b0;
    for (int c = 0; c < 200 && run_cnt < 10; c++) begin
      @(negedge clk);
      if (!bus0.core_rst) run_cnt++;
    end
    check("reached_run_10", 32'(run_cnt), 32'd10);
    rst = 1'b1;
    #1;
    check("rst_core_rst", {31'd0, bus0.core_rst}, 32'd1);
    check("rst_busy", {31'd0, bus0.bist_busy}, 32'd0);
    check("rst_imem_we", {31'd0, bus0.imem_we}, 32'd0);
    check("rst_inst_end", {31'd0, bus0.inst_end}, 32'd0);
    check("rst_done", {31'd0, bus0.bist_done}, 32'd0);
    check("rst_pass", {31'd0, bus0.bist_pass}, 32'd0);
    check("rst_imem_addr", bus0.imem_addr, 32'd0);
    check("rst_dmem_raddr", bus0.dmem_raddr, 32'd0);
    check("rst_rv1", {20'd0, bus0.random_value_1}, 32'd0);
    check("rst_rv2", {20'd0, bus0.random_value_2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (bus0.bist_done) done_seen++;
    end
    check("no_done_after_abort", 32'(done_seen), 32'd0);
  endtask

  initial begin
    fixed_words[0]  = 32'h0;
    fixed_words[1]  = 32'h0;
    fixed_words[2]  = 32'h002081B3;
    fixed_words[3]  = 32'h40208233;
    fixed_words[4]  = 32'h0020F2B3;
    fixed_words[5]  = 32'h0020E333;
    fixed_words[6]  = 32'h00109393;
    fixed_words[7]  = 32'h00115413;
    fixed_words[8]  = 32'h00102023;
    fixed_words[9]  = 32'h00202223;
    fixed_words[10] = 32'h00302423;
    fixed_words[11] = 32'h00402623;
    fixed_words[12] = 32'h00502823;
    fixed_words[13] = 32'h00602A23;
    fixed_words[14] = 32'h00702C23;
    fixed_words[15] = 32'h00802E23;
    fixed_words[16] = 32'h0000006F;
    // LFSR sequence from the defaults: 123 -> 246 -> 48C, 456 -> 8AC -> 159.
    runs[0] = '{pf: 1'b1, rv1: 12'h123, rv2: 12'h456, exp_pass: 1'b1};
    runs[1] = '{pf: 1'b0, rv1: 12'h246, rv2: 12'h8AC, exp_pass: 1'b0};
    runs[2] = '{pf: 1'b1, rv1: 12'h48C, rv2: 12'h159, exp_pass: 1'b1};

    bus0.bist_start = 1'b0;
    bus0.P_F        = 1'b0;
    bus1.bist_start = 1'b0;
    bus1.P_F        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_core_rst", {31'd0, bus0.core_rst}, 32'd1);
    check("reset_busy", {31'd0, bus0.bist_busy}, 32'd0);
    check("reset_imem_we", {31'd0, bus0.imem_we}, 32'd0);
    check("reset_done", {31'd0, bus0.bist_done}, 32'd0);
    check("reset_pass", {31'd0, bus0.bist_pass}, 32'd0);
    check("reset_rv1", {20'd0, bus0.random_value_1}, 32'd0);
    rst = 1'b0;

    @(negedge clk);
    bus1.bist_start = 1'b1;
    @(negedge clk);
    bus1.bist_start = 1'b0;
    check("seed0_rv1", {20'd0, bus1.random_value_1}, 32'h001);
    check("seed0_rv2", {20'd0, bus1.random_value_2}, 32'h456);

    for (int i = 0; i < 3; i++) do_run(runs[i]);

    reset_mid_run();
    do_run(runs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
